// File: rtl/exe_muldiv_seq.sv
// exe_muldiv_seq
//   Multi-cycle multiply/divide sequencer that sits beside the execute stage.
//   Execute hands over one op, the pipeline is held through stall_o while a
//   one-bit-per-cycle shift-add multiplier or restoring divider runs. The
//   result is then presented for a single cycle (done_o) so execute can
//   capture it.
//
//   Optional feature macro: BEXKAT_MULDIV_SIGNED_EN
//     defined     : op_i[2]=1 selects two's-complement operation.
//     not defined : op_i[2] is ignored and every op is unsigned.
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous, active-high reset
//   start_i      op request, sampled only in IDLE
//   op_i[2:0]    [1:0] 00=MUL 01=DIV 10=MOD 11=reserved, [2]=signed
//   a_i, b_i     operands (multiplicand/dividend, multiplier/divisor)
//   flush_i      abort any in-flight op, highest priority
//   stall_o      pipeline hold request
//   busy_o       sequencer not in IDLE
//   done_o       one-cycle pulse, result_o valid
//   result_o     result, held until a new result is written
//   divz_o       divide-by-zero flag, valid with done_o
//   dbg_state_o  current FSM state (debug/observability)
//
// Handshake: an op is accepted on a rising edge where the FSM is IDLE,
// start_i=1 and flush_i=0. Nothing is queued: start_i outside IDLE is
// dropped. done_o is asserted for exactly one cycle per completed op and
// never for a flushed one.
//
// Short ops (reserved opcode, divide by zero) still pass through BUSY for one
// cycle, so their done_o arrives two cycles after acceptance.

module exe_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             divz_o,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_MOD = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  logic [1:0]       state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [1:0]       op_q,     op_d;
  logic             short_q,  short_d;
  // MUL: acc=partial product, opa=shifted multiplicand, opb=shifted multiplier
  // DIV/MOD: acc=partial remainder, opa=dividend shifting into quotient, opb=divisor
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] opa_q,    opa_d;
  logic [WIDTH-1:0] opb_q,    opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             divz_q,   divz_d;
`ifdef BEXKAT_MULDIV_SIGNED_EN
  logic             neg_q,    neg_d;
`else
  logic             unused_sign;
  assign unused_sign = op_i[2];
`endif

  // One multiply iteration
  logic [WIDTH-1:0] mul_acc, mul_opa, mul_opb;
  assign mul_acc = opb_q[0] ? (acc_q + opa_q) : acc_q;
  assign mul_opa = opa_q << 1;
  assign mul_opb = opb_q >> 1;

  // One restoring-divide iteration: bring the next dividend bit into the
  // remainder and subtract the divisor if it fits.
  logic [WIDTH:0]   div_shift, div_diff;
  logic [WIDTH-1:0] div_acc, div_opa;
  assign div_shift = {acc_q, opa_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_acc   = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign div_opa   = {opa_q[WIDTH-2:0], ~div_diff[WIDTH]};

  // Operand magnitudes and result sign captured at acceptance
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             neg_in;
  always_comb begin
    a_mag  = a_i;
    b_mag  = b_i;
    neg_in = 1'b0;
`ifdef BEXKAT_MULDIV_SIGNED_EN
    if (op_i[2]) begin
      a_mag  = a_i[WIDTH-1] ? (~a_i + 1'b1) : a_i;
      b_mag  = b_i[WIDTH-1] ? (~b_i + 1'b1) : b_i;
      // remainder follows the dividend's sign, product/quotient the xor
      neg_in = (op_i[1:0] == OP_MOD) ? a_i[WIDTH-1] : (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    end
`endif
  end

  // Final value selected on the last iteration
  logic [WIDTH-1:0] final_mag, final_res;
  always_comb begin
    case (op_q)
      OP_MUL:  final_mag = mul_acc;
      OP_DIV:  final_mag = div_opa;
      default: final_mag = div_acc;
    endcase
    final_res = final_mag;
`ifdef BEXKAT_MULDIV_SIGNED_EN
    if (neg_q) final_res = ~final_mag + 1'b1;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    short_d  = short_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    divz_d   = divz_q;
`ifdef BEXKAT_MULDIV_SIGNED_EN
    neg_d    = neg_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
          op_d    = op_i[1:0];
          short_d = 1'b0;
          divz_d  = 1'b0;
          acc_d   = '0;
          opa_d   = a_mag;
          opb_d   = b_mag;
`ifdef BEXKAT_MULDIV_SIGNED_EN
          neg_d   = neg_in;
`endif
          if (op_i[1:0] == OP_RSV) begin
            short_d = 1'b1;
            acc_d   = '0;
          end else if ((op_i[1:0] != OP_MUL) && (b_i == '0)) begin
            // divide by zero: result is preloaded into acc, raw a_i for MOD
            short_d = 1'b1;
            divz_d  = 1'b1;
            acc_d   = (op_i[1:0] == OP_DIV) ? '1 : a_i;
          end
        end
      end
      ST_BUSY: begin
        if (short_q) begin
          result_d = acc_q;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (op_q == OP_MUL) begin
            acc_d = mul_acc;
            opa_d = mul_opa;
            opb_d = mul_opb;
          end else begin
            acc_d = div_acc;
            opa_d = div_opa;
          end
          if (cnt_q == LAST_CNT) begin
            result_d = final_res;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // flush overrides everything: back to IDLE, keep the old result
    if (flush_i) begin
      state_d  = ST_IDLE;
      result_d = result_q;
      divz_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      short_q  <= 1'b0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      divz_q   <= 1'b0;
`ifdef BEXKAT_MULDIV_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      short_q  <= short_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      divz_q   <= divz_d;
`ifdef BEXKAT_MULDIV_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign stall_o     = ((state_q == ST_IDLE) && start_i) || (state_q == ST_BUSY);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign result_o    = result_q;
  assign divz_o      = divz_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_exe_muldiv_seq.sv
module tb_exe_muldiv_seq;

  localparam int W = 32;

  logic         clk_i;
  logic         rst_i;
  logic         start_i;
  logic [2:0]   op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         flush_i;
  logic         stall_o;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic         divz_o;
  logic [1:0]   dbg_state_o;

  int total = 0;
  int bad   = 0;

  exe_muldiv_seq #(.WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .op_i        (op_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .flush_i     (flush_i),
    .stall_o     (stall_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_o    (result_o),
    .divz_o      (divz_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Driver: present one op at cycle 0, scramble operands after acceptance,
  // then wait (bounded) for done_o. lat = cycle index of done_o (-1 on
  // timeout), stall_cnt = cycles with stall_o high before done_o.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int lat, output int stall_cnt);
    @(negedge clk_i);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    #1;
    stall_cnt = stall_o ? 1 : 0;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    a_i     = 32'hDEAD_BEEF;
    b_i     = 32'h1234_5678;
    op_i    = 3'b011;
    lat     = -1;
    for (int n = 1; n < 100; n++) begin
      @(negedge clk_i);
      if (done_o) begin
        lat = n;
        break;
      end
      if (stall_o) stall_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0;
    op_i = 3'b000; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || stall_o !== 1'b0 || divz_o !== 1'b0 ||
        result_o !== 32'h0 || dbg_state_o !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b stall=%b divz=%b result=%h state=%0d, required all zero",
               busy_o, done_o, stall_o, divz_o, result_o, dbg_state_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic check_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res,
                          input logic exp_divz, input int exp_lat, input int exp_stall);
    int lat, sc;
    run_op(op, a, b, lat, sc);
    total++;
    if (lat !== exp_lat) begin
      bad++;
      $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
    end
    total++;
    if (result_o !== exp_res || divz_o !== exp_divz) begin
      bad++;
      $display("FAIL %s_result: got %h divz=%b required %h divz=%b", name, result_o, divz_o, exp_res, exp_divz);
    end
    total++;
    if (sc !== exp_stall || stall_o !== 1'b0) begin
      bad++;
      $display("FAIL %s_stall: stall cycles %0d stall_at_done=%b required %0d and 0", name, sc, stall_o, exp_stall);
    end
  endtask

  task automatic test_mul();
    check_op("mul_7x6",   3'b000, 32'd7,         32'd6,        32'd42,         1'b0, 33, 33);
    check_op("mul_wrap",  3'b000, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFE,  1'b0, 33, 33);
    check_op("mul_ovf",   3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0,         1'b0, 33, 33);
  endtask

  task automatic test_div();
    check_op("div_100_7", 3'b001, 32'd100,       32'd7,  32'd14,        1'b0, 33, 33);
    check_op("mod_100_7", 3'b010, 32'd100,       32'd7,  32'd2,         1'b0, 33, 33);
    check_op("div_max_1", 3'b001, 32'hFFFF_FFFF, 32'd1,  32'hFFFF_FFFF, 1'b0, 33, 33);
    check_op("mod_7_100", 3'b010, 32'd7,         32'd100, 32'd7,        1'b0, 33, 33);
  endtask

  task automatic test_divz();
    check_op("div_5_0",  3'b001, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 2, 2);
    check_op("mod_5_0",  3'b010, 32'd5, 32'd0, 32'd5,         1'b1, 2, 2);
    check_op("reserved", 3'b011, 32'd5, 32'd9, 32'd0,         1'b0, 2, 2);
    // flush alone clears the held divz flag
    check_op("div_9_0",  3'b001, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b1, 2, 2);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    total++;
    if (divz_o !== 1'b0 || result_o !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL flush_divz: divz=%b result=%h required 0 and ffffffff", divz_o, result_o);
    end
  endtask

  task automatic test_flush();
    int dones;
    check_op("flush_base", 3'b001, 32'd100, 32'd7, 32'd14, 1'b0, 33, 33);
    @(negedge clk_i);
    start_i = 1'b1; op_i = 3'b000; a_i = 32'd3; b_i = 32'd3;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    dones = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk_i);
      if (done_o) dones++;
      start_i = (n == 3);
      op_i    = 3'b001;
      flush_i = (n == 10);
    end
    @(negedge clk_i);
    flush_i = 1'b0;
    total++;
    if (busy_o !== 1'b0 || stall_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'd14) begin
      bad++;
      $display("FAIL flush_idle: busy=%b stall=%b done=%b result=%h required 0 0 0 0000000e",
               busy_o, stall_o, done_o, result_o);
    end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_i);
      if (done_o) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL flush_no_done: done pulses %0d required 0", dones);
    end
    // start together with flush in IDLE: stall follows the formula, no accept
    @(negedge clk_i);
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'b000;
    #1;
    total++;
    if (stall_o !== 1'b1) begin
      bad++;
      $display("FAIL flush_start_stall: got %b required 1", stall_o);
    end
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b0;
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_start_accept: busy=%b required 0", busy_o);
    end
  endtask

  task automatic test_back_to_back();
    int lat, sc;
    // start_i pulses in BUSY and DONE must be dropped
    @(negedge clk_i);
    start_i = 1'b1; op_i = 3'b000; a_i = 32'd7; b_i = 32'd6;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    lat = -1;
    for (int n = 1; n < 100; n++) begin
      @(negedge clk_i);
      start_i = (n == 5);
      op_i    = 3'b001; a_i = 32'd1; b_i = 32'd1;
      if (done_o) begin
        lat = n;
        start_i = 1'b1;
        break;
      end
    end
    total++;
    if (lat !== 33 || result_o !== 32'd42) begin
      bad++;
      $display("FAIL busy_start_ignored: lat=%0d result=%h required 33 0000002a", lat, result_o);
    end
    @(negedge clk_i);
    start_i = 1'b0;
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'd42) begin
      bad++;
      $display("FAIL done_start_ignored: busy=%b done=%b result=%h required 0 0 0000002a",
               busy_o, done_o, result_o);
    end
    check_op("b2b_mul", 3'b000, 32'd12345, 32'd1000, 32'd12345000, 1'b0, 33, 33);
  endtask

  task automatic test_signed();
`ifdef BEXKAT_MULDIV_SIGNED_EN
    check_op("sdiv_m7_2",   3'b101, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 33, 33);
    check_op("smod_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 33, 33);
    check_op("sdiv_min_m1", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33, 33);
    check_op("smod_min_m1", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, 33, 33);
    check_op("smul_m3_5",   3'b100, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 1'b0, 33, 33);
    check_op("smod_m5_0",   3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b1, 2, 2);
`else
    check_op("udiv_m7_2",   3'b101, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 1'b0, 33, 33);
    check_op("umod_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2,         32'd1,         1'b0, 33, 33);
    check_op("udiv_min_m1", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, 33, 33);
    check_op("umod_min_m1", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33, 33);
`endif
  endtask

  task automatic test_reset_mid();
    check_op("pre_rst", 3'b000, 32'd9, 32'd9, 32'd81, 1'b0, 33, 33);
    @(negedge clk_i);
    start_i = 1'b1; op_i = 3'b001; a_i = 32'd1000; b_i = 32'd3;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || stall_o !== 1'b0 || divz_o !== 1'b0 ||
        result_o !== 32'h0 || dbg_state_o !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid_busy: busy=%b done=%b stall=%b divz=%b result=%h state=%0d, required all zero",
               busy_o, done_o, stall_o, divz_o, result_o, dbg_state_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    check_op("post_rst", 3'b001, 32'd1000, 32'd3, 32'd333, 1'b0, 33, 33);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_divz();
    test_flush();
    test_back_to_back();
    test_signed();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
